// File: rtl/spi_sram_responder.sv
// SPI slave emulating a byte-addressed serial SRAM (READ 0x03 / WRITE 0x02).
// All SPI pins are oversampled in the clk domain; nothing is clocked by SCK.
module spi_sram_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SCK,
    input  logic                 CE,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic                 miso_oe,
    input  logic                 CPOL,
    input  logic                 CPHA,
    output logic                 busy,
    output logic                 cmd_err,
    output logic                 wr_strobe,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data
);

    typedef enum logic [3:0] {
        IDLE, CMD, RADDR_H, RADDR_L, WADDR_H, WADDR_L, READ, WRITE, IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, ce_sync, mosi_sync;
    logic                   sck_s, ce_s, mosi_s, sck_n, sck_prev, ce_prev;
    logic                   active, lead, trail, sample, shift, byte_done;
    logic [2:0]             cnt;
    logic [7:0]             rx, rx_nxt, tx, addr_hi;
    logic [15:0]            a16;
    logic [ADDR_BITS-1:0]   a_low, addr, rd_addr;
    logic                   commit, cmd_bad, load_tx, miso_q, oe_q;
    logic                   unused_addr_bits;
    logic [7:0]             mem [0:(2**ADDR_BITS)-1];

    // CE synchroniser resets low so a fall is only seen after CE was observed high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            ce_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            ce_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            ce_sync   <= {ce_sync[SYNC_STAGES-2:0], CE};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_prev  <= sck_n;
            ce_prev   <= ce_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ce_s   = ce_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign sck_n  = sck_s ^ CPOL;

    // Gating on the previous CE sample lets a final edge coincident with CE rise complete
    assign active    = (state != IDLE) && !ce_prev;
    assign lead      = active && sck_n && !sck_prev;
    assign trail     = active && !sck_n && sck_prev;
    assign sample    = CPHA ? trail : lead;
    assign shift     = CPHA ? lead : trail;
    assign byte_done = sample && (cnt == 3'd7);
    assign rx_nxt    = {rx[6:0], mosi_s};

    assign a16              = {addr_hi, rx_nxt};
    assign a_low            = a16[ADDR_BITS-1:0];
    assign unused_addr_bits = ^a16;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ce_prev && !ce_s) state_nxt = CMD;
            default: begin
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            if (rx_nxt == 8'h03)      state_nxt = RADDR_H;
                            else if (rx_nxt == 8'h02) state_nxt = WADDR_H;
                            else                      state_nxt = IGNORE;
                        end
                        RADDR_H: state_nxt = RADDR_L;
                        RADDR_L: state_nxt = READ;
                        WADDR_H: state_nxt = WADDR_L;
                        WADDR_L: state_nxt = WRITE;
                        default: state_nxt = state;
                    endcase
                end
                if (ce_s) state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        commit  = byte_done && (state == WRITE);
        cmd_bad = byte_done && (state == CMD) && (rx_nxt != 8'h02) && (rx_nxt != 8'h03);
        load_tx = byte_done && ((state == RADDR_L) || (state == READ));
        rd_addr = (state == RADDR_L) ? a_low : addr;
        MISO    = (state == READ) ? miso_q : 1'b1;
        miso_oe = (state == READ) && oe_q;
        busy    = !ce_s && (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rx        <= '0;
            tx        <= 8'hFF;
            addr_hi   <= '0;
            addr      <= '0;
            miso_q    <= 1'b1;
            oe_q      <= 1'b0;
            cmd_err   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            cmd_err   <= cmd_bad;
            wr_strobe <= commit;
            if (state == IDLE) cnt <= '0;
            else if (sample)   cnt <= cnt + 1'b1;
            if (sample) rx <= rx_nxt;
            if (byte_done) begin
                case (state)
                    RADDR_H, WADDR_H: addr_hi <= rx_nxt;
                    RADDR_L:          addr    <= a_low + 1'b1;
                    WADDR_L:          addr    <= a_low;
                    READ, WRITE:      addr    <= addr + 1'b1;
                    default:          ;
                endcase
            end
            if (commit) begin
                wr_addr <= addr;
                wr_data <= rx_nxt;
            end
            if (load_tx)                     tx <= mem[rd_addr];
            else if (shift && state == READ) tx <= {tx[6:0], 1'b1};
            if (state != READ) begin
                miso_q <= 1'b1;
                oe_q   <= 1'b0;
            end else if (shift) begin
                miso_q <= tx[7];
                oe_q   <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (commit) mem[addr] <= rx_nxt;
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: table of write/read transactions in all
// four SPI modes plus hand-written abort, CE-coincident and reset sequences.
module tb_spi_sram_responder;

    logic       clk = 1'b0, rst = 1'b1;
    logic       SCK = 1'b0, CE = 1'b1, MOSI = 1'b0, CPOL = 1'b0, CPHA = 1'b0;
    logic       MISO, miso_oe, busy, cmd_err, wr_strobe;
    logic [7:0] wr_addr, wr_data;

    always #5 clk = ~clk;

    spi_sram_responder #(.ADDR_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .CE(CE), .MOSI(MOSI), .MISO(MISO),
        .miso_oe(miso_oe), .CPOL(CPOL), .CPHA(CPHA), .busy(busy), .cmd_err(cmd_err),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int          n_cmp = 0, n_bad = 0, n_err = 0, miso_bad = 0;
    logic [15:0] strobes[$];

    always @(negedge clk) begin
        if (wr_strobe) strobes.push_back({wr_addr, wr_data});
        if (cmd_err) n_err++;
        if (!miso_oe && MISO !== 1'b1) miso_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic set_mode(input logic [1:0] m);
        CPOL = m[1];
        CPHA = m[0];
        SCK  = m[1];
        half();
    endtask

    task automatic spi_bit(input logic b, output logic r, output logic oe);
        if (!CPHA) begin
            MOSI = b; half(); r = MISO; oe = miso_oe;
            SCK = ~CPOL; half(); SCK = CPOL;
        end else begin
            SCK = ~CPOL; MOSI = b; half(); r = MISO; oe = miso_oe;
            SCK = CPOL; half();
        end
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] r,
                            output logic oe_any, output logic oe_all);
        logic rb, o;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(d[i], rb, o);
            r[i]   = rb;
            oe_any = oe_any | o;
            oe_all = oe_all & o;
        end
    endtask

    // Full transaction: command, 16-bit address, two data bytes
    task automatic txn(input logic [7:0] cmd, input logic [15:0] a, input logic [7:0] d0,
                       input logic [7:0] d1, output logic [7:0] r0, output logic [7:0] r1,
                       output logic hdr_oe, output logic doe_any, output logic doe_all);
        logic [7:0] r;
        logic       x, y, x2, y2;
        CE = 1'b0; half();
        spi_byte(cmd, r, hdr_oe, y);
        spi_byte(a[15:8], r, x, y); hdr_oe = hdr_oe | x;
        spi_byte(a[7:0], r, x, y);  hdr_oe = hdr_oe | x;
        spi_byte(d0, r0, x, y);
        spi_byte(d1, r1, x2, y2);
        doe_any = x | x2;
        doe_all = y & y2;
        half(); CE = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [7:0]  d0, d1;
        int          n_str;
        logic [15:0] s0, s1;   // {addr, data} of expected strobes
        int          n_err;
        logic [7:0]  r0, r1;
        logic        oe_data;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [7:0] r0, r1, rb8;
        logic       hoe, doa, dol, rb, o;
        int         e0;

        vt[0]  = '{2'b00, 8'h02, 16'h0010, 8'hA5, 8'h5A, 2, 16'h10A5, 16'h115A, 0, 8'hFF, 8'hFF, 1'b0};
        vt[1]  = '{2'b00, 8'h03, 16'h0010, 8'hFF, 8'hFF, 0, 16'h0000, 16'h0000, 0, 8'hA5, 8'h5A, 1'b1};
        vt[2]  = '{2'b01, 8'h02, 16'h0030, 8'h3C, 8'hC3, 2, 16'h303C, 16'h31C3, 0, 8'hFF, 8'hFF, 1'b0};
        vt[3]  = '{2'b01, 8'h03, 16'h0030, 8'hFF, 8'hFF, 0, 16'h0000, 16'h0000, 0, 8'h3C, 8'hC3, 1'b1};
        vt[4]  = '{2'b10, 8'h02, 16'h0040, 8'h3C, 8'h81, 2, 16'h403C, 16'h4181, 0, 8'hFF, 8'hFF, 1'b0};
        vt[5]  = '{2'b10, 8'h03, 16'h0040, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h3C, 8'h81, 1'b1};
        vt[6]  = '{2'b11, 8'h02, 16'h0050, 8'h3C, 8'h7E, 2, 16'h503C, 16'h517E, 0, 8'hFF, 8'hFF, 1'b0};
        vt[7]  = '{2'b11, 8'h03, 16'h0050, 8'hFF, 8'hFF, 0, 16'h0000, 16'h0000, 0, 8'h3C, 8'h7E, 1'b1};
        vt[8]  = '{2'b00, 8'h02, 16'h00FF, 8'h11, 8'h22, 2, 16'hFF11, 16'h0022, 0, 8'hFF, 8'hFF, 1'b0};
        vt[9]  = '{2'b00, 8'h03, 16'h00FF, 8'hFF, 8'hFF, 0, 16'h0000, 16'h0000, 0, 8'h11, 8'h22, 1'b1};
        vt[10] = '{2'b00, 8'h9F, 16'h0010, 8'h12, 8'h34, 0, 16'h0000, 16'h0000, 1, 8'hFF, 8'hFF, 1'b0};
        vt[11] = '{2'b11, 8'h03, 16'hAB10, 8'hFF, 8'hFF, 0, 16'h0000, 16'h0000, 0, 8'hA5, 8'h5A, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_miso", MISO, 1'b1);
        chk("rst_oe", miso_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            set_mode(vt[v].mode);
            strobes.delete();
            e0 = n_err;
            txn(vt[v].cmd, vt[v].addr, vt[v].d0, vt[v].d1, r0, r1, hoe, doa, dol);
            chk($sformatf("v%0d_hdr_oe", v), hoe, 1'b0);
            chk($sformatf("v%0d_n_strobe", v), strobes.size(), vt[v].n_str);
            if (vt[v].n_str > 0 && strobes.size() > 0) chk($sformatf("v%0d_strobe0", v), strobes[0], vt[v].s0);
            if (vt[v].n_str > 1 && strobes.size() > 1) chk($sformatf("v%0d_strobe1", v), strobes[1], vt[v].s1);
            chk($sformatf("v%0d_cmd_err", v), n_err - e0, vt[v].n_err);
            chk($sformatf("v%0d_rd0", v), r0, vt[v].r0);
            chk($sformatf("v%0d_rd1", v), r1, vt[v].r1);
            chk($sformatf("v%0d_oe_any", v), doa, vt[v].oe_data);
            chk($sformatf("v%0d_oe_all", v), dol, vt[v].oe_data);
        end

        // Abort mid-byte: the partial byte must not reach memory
        set_mode(2'b00);
        strobes.delete();
        txn(8'h02, 16'h0020, 8'h66, 8'h67, r0, r1, hoe, doa, dol);
        chk("abort_pre_strobes", strobes.size(), 2);
        strobes.delete();
        CE = 1'b0; half();
        spi_byte(8'h02, rb8, hoe, dol);
        spi_byte(8'h00, rb8, hoe, dol);
        spi_byte(8'h20, rb8, hoe, dol);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, rb, o);
        chk("abort_busy_mid", busy, 1'b1);
        CE = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_busy_after", busy, 1'b0);
        chk("abort_miso_after", MISO, 1'b1);
        repeat (12) @(negedge clk);
        chk("abort_n_strobe", strobes.size(), 0);
        txn(8'h03, 16'h0020, 8'hFF, 8'hFF, r0, r1, hoe, doa, dol);
        chk("abort_readback", r0, 8'h66);

        // CE rises in the same step as the last write sample edge (mode 1)
        set_mode(2'b01);
        strobes.delete();
        CE = 1'b0; half();
        spi_byte(8'h02, rb8, hoe, dol);
        spi_byte(8'h00, rb8, hoe, dol);
        spi_byte(8'h60, rb8, hoe, dol);
        for (int i = 7; i >= 1; i--) spi_bit(((8'h5D >> i) & 8'h01) != 8'h00, rb, o);
        SCK = ~CPOL; MOSI = 1'b1; half();
        SCK = CPOL; CE = 1'b1;
        repeat (16) @(negedge clk);
        chk("ce_edge_n_strobe", strobes.size(), 1);
        if (strobes.size() > 0) chk("ce_edge_strobe", strobes[0], 16'h605D);
        txn(8'h03, 16'h0060, 8'hFF, 8'hFF, r0, r1, hoe, doa, dol);
        chk("ce_edge_readback", r0, 8'h5D);

        // Reset during the second bit of a read data byte (mode 0)
        set_mode(2'b00);
        CE = 1'b0; half();
        spi_byte(8'h03, rb8, hoe, dol);
        spi_byte(8'h00, rb8, hoe, dol);
        spi_byte(8'h10, rb8, hoe, dol);
        spi_bit(1'b1, rb, o);
        chk("rstmid_bit7", rb, 1'b1);
        MOSI = 1'b1; half();
        chk("rstmid_bit6", MISO, 1'b0);
        chk("rstmid_oe_pre", miso_oe, 1'b1);
        chk("rstmid_busy_pre", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstmid_miso", MISO, 1'b1);
        chk("rstmid_oe", miso_oe, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        SCK = CPOL;
        repeat (4) @(negedge clk);
        // CE still low since reset: this traffic must be ignored
        strobes.delete();
        spi_byte(8'h02, rb8, hoe, dol);
        spi_byte(8'h00, rb8, hoe, dol);
        spi_byte(8'h10, rb8, hoe, dol);
        spi_byte(8'h77, rb8, hoe, dol);
        chk("rstmid_ignored_busy", busy, 1'b0);
        CE = 1'b1;
        repeat (16) @(negedge clk);
        chk("rstmid_ignored_strobe", strobes.size(), 0);
        txn(8'h03, 16'h0010, 8'hFF, 8'hFF, r0, r1, hoe, doa, dol);
        chk("rstmid_readback", r0, 8'hA5);

        chk("miso_idle_high", miso_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
